// File: rtl/program_loader.sv
// Byte-stream program loader for the 4-bit CPU: header byte gives the word count,
// then each 11-bit instruction arrives as a HI/LO byte pair and is written to program RAM.
module program_loader #(
  parameter int DW = 11,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          RAM_Write_Enable,
  output logic [AW-1:0] RAM_Write_Address,
  output logic [DW-1:0] RAM_Write_Data,
  output logic          PC_Enable,
  output logic          busy,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HI,
    S_LO,
    S_WRITE,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state, state_next;
  logic [3:0]    count;
  logic [AW-1:0] index;
  logic [2:0]    word_hi;
  logic          accept;
  logic          load_clear;
  logic          idx_inc;
  logic          last_word;

  assign accept    = rx_valid && rx_ready;
  assign last_word = (int'(index) + 1) == int'(count);

  always_comb begin
    state_next = state;
    load_clear = 1'b0;
    idx_inc    = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_next = S_HDR;
            load_clear = 1'b1;
          end
        end
        S_HDR: begin
          if (accept) begin
            if (rx_data[7:4] != 4'd0 || rx_data[3:0] == 4'd0 ||
                {1'b0, rx_data[3:0]} > 5'(DEPTH))
              state_next = S_ERR;
            else
              state_next = S_HI;
          end
        end
        S_HI: begin
          if (accept) begin
            if (rx_data[7:3] != 5'd0) state_next = S_ERR;
            else                      state_next = S_LO;
          end
        end
        S_LO: begin
          if (accept) state_next = S_WRITE;
        end
        S_WRITE: begin
          if (last_word) begin
            state_next = S_RUN;
          end else begin
            state_next = S_HI;
            idx_inc    = 1'b1;
          end
        end
        S_RUN, S_ERR: begin
          if (start) begin
            state_next = S_HDR;
            load_clear = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      rx_ready          <= 1'b0;
      RAM_Write_Enable  <= 1'b0;
      RAM_Write_Address <= '0;
      RAM_Write_Data    <= '0;
      PC_Enable         <= 1'b0;
      busy              <= 1'b0;
      err               <= 1'b0;
      words_loaded      <= '0;
      count             <= '0;
      index             <= '0;
      word_hi           <= '0;
    end else begin
      state            <= state_next;
      rx_ready         <= (state_next == S_HDR) || (state_next == S_HI) || (state_next == S_LO);
      busy             <= (state_next == S_HDR) || (state_next == S_HI) ||
                          (state_next == S_LO)  || (state_next == S_WRITE);
      RAM_Write_Enable <= (state_next == S_WRITE);
      PC_Enable        <= (state_next == S_RUN);
      err              <= (state_next == S_ERR);

      if (state == S_HDR && accept && !abort) count <= rx_data[3:0];
      if (state == S_HI && accept && !abort)  word_hi <= rx_data[2:0];

      if (state_next == S_WRITE) begin
        RAM_Write_Address <= index;
        RAM_Write_Data    <= DW'({word_hi, rx_data});
      end

      if (load_clear) begin
        index        <= '0;
        words_loaded <= '0;
      end else begin
        if (idx_inc) index <= index + 1'b1;
        if (state == S_WRITE) words_loaded <= words_loaded + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table vectors, directed corner sequences,
// and randomized loads checked against a byte-stream parsing model.
module tb_program_loader;
  localparam int DW = 11;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, start, abort, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, RAM_Write_Enable, PC_Enable, busy, err;
  logic [AW-1:0] RAM_Write_Address;
  logic [DW-1:0] RAM_Write_Data;
  logic [AW:0]   words_loaded;

  program_loader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .RAM_Write_Enable(RAM_Write_Enable), .RAM_Write_Address(RAM_Write_Address),
    .RAM_Write_Data(RAM_Write_Data), .PC_Enable(PC_Enable), .busy(busy),
    .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct {
    logic [7:0] b[5];
    int         n;
    bit         e;
    bit         pc;
    int         words;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  got[$];
  wr_t  exp_wr[$];
  vec_t tbl[7];

  always @(negedge clk) begin
    if (reset && RAM_Write_Enable) begin
      wr_t w;
      w.addr = RAM_Write_Address;
      w.data = RAM_Write_Data;
      got.push_back(w);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_we"}, RAM_Write_Enable, 0);
    check({tag, "_addr"}, RAM_Write_Address, 0);
    check({tag, "_data"}, RAM_Write_Data, 0);
    check({tag, "_pc"}, PC_Enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_words"}, words_loaded, 0);
  endtask

  // Reference: parse the byte stream by the format rules, returning bytes consumed.
  task automatic model(input byte_q_t b, output int used, output bit e, output bit pc);
    int         cnt;
    logic [7:0] hi, lo;
    wr_t        w;
    exp_wr.delete();
    used = 1; e = 0; pc = 0;
    cnt = int'(b[0] & 8'h0F);
    if ((b[0] >> 4) != 0 || cnt == 0 || cnt > 8) begin
      e = 1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      hi = b[1 + 2*i];
      used++;
      if (hi > 8'h07) begin
        e = 1;
        return;
      end
      lo = b[2 + 2*i];
      used++;
      w.addr = AW'(i);
      w.data = DW'(hi * 256 + lo);
      exp_wr.push_back(w);
    end
    pc = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: rx_ready 0 required 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_load(input byte_q_t b, input int gmin, input int gmax);
    int used;
    bit e, pc;
    model(b, used, e, pc);
    got.delete();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", rx_ready, 1);
    check("start_err_clr", err, 0);
    check("start_pc_low", PC_Enable, 0);
    check("start_words_clr", words_loaded, 0);
    for (int i = 0; i < used; i++) send_byte(b[i], int'($urandom_range(gmax, gmin)));
    if (pc) begin
      check("final_we", RAM_Write_Enable, 1);
      check("final_addr", RAM_Write_Address, exp_wr[exp_wr.size()-1].addr);
      check("final_data", RAM_Write_Data, exp_wr[exp_wr.size()-1].data);
      @(negedge clk);
      check("pc_latency", PC_Enable, 1);
      check("we_drop", RAM_Write_Enable, 0);
    end
    repeat (4) @(negedge clk);
    check("n_writes", got.size(), exp_wr.size());
    for (int i = 0; i < got.size() && i < exp_wr.size(); i++) begin
      check("wr_addr", got[i].addr, exp_wr[i].addr);
      check("wr_data", got[i].data, exp_wr[i].data);
    end
    check("end_err", err, e);
    check("end_pc", PC_Enable, pc);
    check("end_words", words_loaded, exp_wr.size());
    check("end_busy", busy, 0);
    check("end_ready", rx_ready, 0);
  endtask

  task automatic set_vec(input int i, input logic [7:0] b0, b1, b2, b3, b4,
                         input int n, input bit e, input bit pc, input int w);
    tbl[i].b[0] = b0; tbl[i].b[1] = b1; tbl[i].b[2] = b2;
    tbl[i].b[3] = b3; tbl[i].b[4] = b4;
    tbl[i].n = n; tbl[i].e = e; tbl[i].pc = pc; tbl[i].words = w;
  endtask

  initial begin
    byte_q_t q;
    int      cnt, mode, bad;

    set_vec(0, 8'h09, 0, 0, 0, 0, 1, 1, 0, 0);
    set_vec(1, 8'h02, 8'h01, 8'h90, 8'h00, 8'h24, 5, 0, 1, 2);
    set_vec(2, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0);
    set_vec(3, 8'h11, 0, 0, 0, 0, 1, 1, 0, 0);
    set_vec(4, 8'h01, 8'h08, 0, 0, 0, 2, 1, 0, 0);
    set_vec(5, 8'h01, 8'h07, 8'hAB, 0, 0, 3, 0, 1, 1);
    set_vec(6, 8'h02, 8'h03, 8'hFF, 8'hF8, 0, 4, 1, 0, 1);

    reset = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1 reset = 1'b0;
    #2 check_reset_outs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", rx_ready, 0);

    for (int i = 0; i < 7; i++) begin
      q.delete();
      for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].b[j]);
      run_load(q, 0, 0);
      check("tbl_err", err, tbl[i].e);
      check("tbl_pc", PC_Enable, tbl[i].pc);
      check("tbl_words", words_loaded, tbl[i].words);
    end

    // Full 8-word program with 2-cycle gaps between bytes.
    q.delete();
    q.push_back(8'h08);
    for (int i = 0; i < 16; i++) q.push_back(8'((i % 2 == 0) ? (i / 2) % 8 : 8'h30 + i));
    run_load(q, 2, 2);

    // Abort and start together while in RUN: start must be ignored.
    @(negedge clk) begin abort = 1'b1; start = 1'b1; end
    @(negedge clk) begin abort = 1'b0; start = 1'b0; end
    check("abort_pc", PC_Enable, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", rx_ready, 0);
    @(negedge clk);
    check("abort_stays_idle", rx_ready, 0);

    // Abort beats a byte offered in LO: no write.
    got.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    rx_valid = 1'b1; rx_data = 8'h55; abort = 1'b1;
    @(negedge clk) begin rx_valid = 1'b0; abort = 1'b0; end
    repeat (3) @(negedge clk);
    check("abort_lo_writes", got.size(), 0);
    check("abort_lo_busy", busy, 0);

    // Reset during the third WRITE of a five-word load.
    q.delete();
    q.push_back(8'h05);
    for (int i = 0; i < 10; i++) q.push_back(8'((i % 2 == 0) ? 3 : 8'hC0 + i));
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(q[i], 0);
    check("mid_we", RAM_Write_Enable, 1);
    check("mid_words", words_loaded, 2);
    #1 reset = 1'b0;
    #1 check_reset_outs("mid_reset");
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("mid_reset_idle", busy, 0);
    run_load(q, 0, 1);

    // Randomized loads, some with deliberately malformed headers or HI bytes.
    for (int it = 0; it < 25; it++) begin
      q.delete();
      cnt  = int'($urandom_range(8, 1));
      mode = int'($urandom_range(9, 0));
      if (mode == 0)
        q.push_back(($urandom_range(1, 0) == 1) ? 8'($urandom_range(15, 9))
                                                : 8'(16 * $urandom_range(15, 1) + cnt));
      else
        q.push_back(8'(cnt));
      bad = (mode == 1) ? int'($urandom_range(cnt - 1, 0)) : -1;
      for (int i = 0; i < cnt; i++) begin
        q.push_back((i == bad) ? 8'($urandom_range(255, 8)) : 8'($urandom_range(7, 0)));
        q.push_back(8'($urandom_range(255, 0)));
      end
      run_load(q, 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
